// File: rtl/tile_link_pkg.sv
// Shared types and default parameters for the tile link controller.
//   link_state_t : link bring-up FSM encoding (also driven on link_state)
//   tx_state_t   : transmit path state
package tile_link_pkg;

    localparam int unsigned DefNumVcs      = 2;
    localparam int unsigned DefFlitWidth   = 32;
    localparam int unsigned DefCreditDepth = 8;
    localparam int unsigned DefTrainFlits  = 16;
    localparam int unsigned DefErrThresh   = 4;

    typedef enum logic [1:0] {
        StDown  = 2'd0,
        StTrain = 2'd1,
        StUp    = 2'd2,
        StFault = 2'd3
    } link_state_t;

    typedef enum logic {
        TxIdle = 1'b0,
        TxBusy = 1'b1
    } tx_state_t;

endpackage

// File: rtl/tile_link_if.sv
// Switch-side flit handshake between a switch output port and the link controller.
//   sw_valid  : switch offers a flit
//   sw_flit   : offered flit
//   sw_vc     : virtual channel of the offered flit
//   sw_accept : controller took the flit this cycle
interface tile_link_if
    import tile_link_pkg::*;
#(
    parameter int unsigned NUM_VCS    = DefNumVcs,
    parameter int unsigned FLIT_WIDTH = DefFlitWidth
);
    localparam int unsigned VcW = $clog2(NUM_VCS);

    logic                  sw_valid;
    logic [FLIT_WIDTH-1:0] sw_flit;
    logic [VcW-1:0]        sw_vc;
    logic                  sw_accept;

    modport master (output sw_valid, output sw_flit, output sw_vc, input sw_accept);
    modport slave  (input sw_valid, input sw_flit, input sw_vc, output sw_accept);

endinterface

// File: rtl/link_credit_ctr.sv
// Saturating up/down credit counter for one virtual channel.
//   load_i  : load count to Depth (link coming up)
//   inc_i   : credit returned by far end
//   dec_i   : credit consumed by an accepted flit
//   count_o : current credit count
//   ovf_o   : sticky, set by a return that arrives at full credit
module link_credit_ctr
    import tile_link_pkg::*;
#(
    parameter int unsigned Depth = DefCreditDepth,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            load_i,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] count_o,
    output logic            ovf_o
);
    localparam logic [CntW-1:0] Full = CntW'(Depth);

    logic [CntW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (load_i) begin
            count_d = Full;
        end else if (inc_i && !dec_i) begin
            if (count_q == Full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CntW'(1);
            end
        end else if (dec_i && !inc_i && count_q != '0) begin
            count_d = count_q - CntW'(1);
        end
        // inc and dec together cancel out
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/tile_link_ctrl.sv
// Tile link controller: link bring-up/fault FSM, credit-based flow control per VC,
// and a single-flit transmit path toward the PHY.
//   sw          : switch handshake (slave side)
//   link_en     : software enable for bring-up
//   tx_flit/tx_start/tx_done : transmitter interface
//   cred_ret    : per-VC credit return pulses
//   rx_done/rx_err : receive status
//   link_up/link_state/credits/err_cnt/credit_ovf : status outputs
module tile_link_ctrl
    import tile_link_pkg::*;
#(
    parameter int unsigned NUM_VCS      = DefNumVcs,
    parameter int unsigned FLIT_WIDTH   = DefFlitWidth,
    parameter int unsigned CREDIT_DEPTH = DefCreditDepth,
    parameter int unsigned TRAIN_FLITS  = DefTrainFlits,
    parameter int unsigned ERR_THRESH   = DefErrThresh,
    localparam int unsigned VcW = $clog2(NUM_VCS),
    localparam int unsigned CW  = $clog2(CREDIT_DEPTH + 1),
    localparam int unsigned EW  = $clog2(ERR_THRESH + 1)
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        link_en,
    tile_link_if.slave                  sw,
    output logic [FLIT_WIDTH-1:0]       tx_flit,
    output logic                        tx_start,
    input  logic                        tx_done,
    input  logic [NUM_VCS-1:0]          cred_ret,
    input  logic                        rx_done,
    input  logic                        rx_err,
    output logic                        link_up,
    output logic [1:0]                  link_state,
    output logic [NUM_VCS-1:0][CW-1:0]  credits,
    output logic [EW-1:0]               err_cnt,
    output logic                        credit_ovf
);
    localparam int unsigned TW = $clog2(TRAIN_FLITS + 1);
    localparam logic [TW-1:0] TrainTgt = TW'(TRAIN_FLITS);
    localparam logic [EW-1:0] ErrTgt   = EW'(ERR_THRESH);

    link_state_t           link_q;
    logic [TW-1:0]         train_q;
    logic [EW-1:0]         err_q;
    tx_state_t             tx_q;
    logic [FLIT_WIDTH-1:0] flit_q;
    logic                  start_q;

    logic               enter_up;
    logic               has_credit;
    logic               accept;
    logic [NUM_VCS-1:0] ovf_vc;

    assign enter_up = (link_q == StTrain) && link_en && (train_q == TrainTgt);

    // Only an in-range VC can match, so out-of-range sw_vc never has credit.
    always_comb begin
        has_credit = 1'b0;
        for (int unsigned v = 0; v < NUM_VCS; v++) begin
            if (sw.sw_vc == VcW'(v) && credits[v] != '0) begin
                has_credit = 1'b1;
            end
        end
    end

    assign accept       = (link_q == StUp) && (tx_q == TxIdle) && sw.sw_valid && has_credit;
    assign sw.sw_accept = accept;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            link_q  <= StDown;
            train_q <= '0;
            err_q   <= '0;
        end else begin
            case (link_q)
                StDown: begin
                    if (link_en) begin
                        link_q  <= StTrain;
                        train_q <= '0;
                    end
                end
                StTrain: begin
                    if (!link_en) begin
                        link_q <= StDown;
                    end else if (train_q == TrainTgt) begin
                        link_q <= StUp;
                        err_q  <= '0;
                    end else if (rx_done) begin
                        train_q <= rx_err ? '0 : train_q + TW'(1);
                    end
                end
                StUp: begin
                    if (!link_en) begin
                        link_q <= StDown;
                    end else if (err_q == ErrTgt) begin
                        link_q <= StFault;
                    end else if (rx_done && rx_err) begin
                        err_q <= err_q + EW'(1);
                    end
                end
                StFault: begin
                    if (!link_en) begin
                        link_q <= StDown;
                    end
                end
                default: link_q <= StDown;
            endcase
        end
    end

    // Leaving UP abandons any flit in flight.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            tx_q    <= TxIdle;
            flit_q  <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (tx_q)
                TxIdle: begin
                    if (accept) begin
                        tx_q    <= TxBusy;
                        flit_q  <= sw.sw_flit;
                        start_q <= 1'b1;
                    end
                end
                TxBusy: begin
                    if (tx_done || link_q != StUp) begin
                        tx_q <= TxIdle;
                    end
                end
                default: tx_q <= TxIdle;
            endcase
        end
    end

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
        link_credit_ctr #(
            .Depth (CREDIT_DEPTH),
            .CntW  (CW)
        ) u_ctr (
            .clk     (clk),
            .n_rst   (n_rst),
            .load_i  (enter_up),
            .inc_i   (cred_ret[v] && link_q == StUp),
            .dec_i   (accept && sw.sw_vc == VcW'(v)),
            .count_o (credits[v]),
            .ovf_o   (ovf_vc[v])
        );
    end

    assign tx_flit    = flit_q;
    assign tx_start   = start_q;
    assign link_up    = (link_q == StUp);
    assign link_state = link_q;
    assign err_cnt    = err_q;
    assign credit_ovf = |ovf_vc;

endmodule

// File: tb/tb_tile_link_ctrl.sv
// Directed bench for tile_link_ctrl with a behavioural reference model that is
// compared against the DUT on every falling edge.
module tb_tile_link_ctrl;
    localparam int NV    = 2;
    localparam int FW    = 32;
    localparam int DEPTH = 8;
    localparam int TRAIN = 16;
    localparam int ETH   = 4;

    logic clk = 1'b0;
    logic n_rst, link_en, tx_done, rx_done, rx_err, tx_start, link_up, credit_ovf;
    logic [FW-1:0]       tx_flit;
    logic [NV-1:0]       cred_ret;
    logic [1:0]          link_state;
    logic [NV-1:0][3:0]  credits;
    logic [2:0]          err_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tile_link_if #(.NUM_VCS(NV), .FLIT_WIDTH(FW)) sw_if ();

    tile_link_ctrl #(
        .NUM_VCS(NV), .FLIT_WIDTH(FW), .CREDIT_DEPTH(DEPTH),
        .TRAIN_FLITS(TRAIN), .ERR_THRESH(ETH)
    ) dut (
        .clk(clk), .n_rst(n_rst), .link_en(link_en), .sw(sw_if.slave),
        .tx_flit(tx_flit), .tx_start(tx_start), .tx_done(tx_done),
        .cred_ret(cred_ret), .rx_done(rx_done), .rx_err(rx_err),
        .link_up(link_up), .link_state(link_state), .credits(credits),
        .err_cnt(err_cnt), .credit_ovf(credit_ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_state = 0;   // 0 down, 1 train, 2 up, 3 fault
    int         m_train = 0;
    int         m_err   = 0;
    int         m_cred[NV];
    bit         m_ovf   = 0;
    bit         m_busy  = 0;
    bit         m_start = 0;
    logic [FW-1:0] m_flit = '0;

    initial for (int v = 0; v < NV; v++) m_cred[v] = 0;

    function automatic bit model_accept();
        int vc;
        vc = int'(sw_if.sw_vc);
        return (m_state == 2) && !m_busy && sw_if.sw_valid && (vc < NV) && (m_cred[vc] > 0);
    endfunction

    task automatic model_step(input bit acc);
        bit up, entering;
        int net;
        if (!n_rst) begin
            m_state = 0; m_train = 0; m_err = 0; m_ovf = 0;
            m_busy = 0; m_start = 0; m_flit = '0;
            for (int v = 0; v < NV; v++) m_cred[v] = 0;
            return;
        end
        up       = (m_state == 2);
        entering = (m_state == 1) && link_en && (m_train == TRAIN);
        m_start  = acc;
        if (acc) begin
            m_busy = 1;
            m_flit = sw_if.sw_flit;
        end else if (m_busy && (!up || tx_done)) begin
            m_busy = 0;
        end
        for (int v = 0; v < NV; v++) begin
            if (entering) begin
                m_cred[v] = DEPTH;
            end else if (up) begin
                net = int'(cred_ret[v]) - ((acc && int'(sw_if.sw_vc) == v) ? 1 : 0);
                if (net > 0) begin
                    if (m_cred[v] == DEPTH) m_ovf = 1;
                    else m_cred[v]++;
                end else if (net < 0) begin
                    m_cred[v]--;
                end
            end
        end
        case (m_state)
            0: if (link_en) begin m_state = 1; m_train = 0; end
            1: begin
                if (!link_en) m_state = 0;
                else if (m_train == TRAIN) begin m_state = 2; m_err = 0; end
                else if (rx_done) m_train = rx_err ? 0 : m_train + 1;
            end
            2: begin
                if (!link_en) m_state = 0;
                else if (m_err == ETH) m_state = 3;
                else if (rx_done && rx_err) m_err++;
            end
            default: if (!link_en) m_state = 0;
        endcase
    endtask

    // Inputs change only just after rising edges, so on the falling edge the
    // current inputs are those the next rising edge will sample.
    always @(negedge clk) begin
        bit acc;
        acc = model_accept();
        chk("sw_accept", sw_if.sw_accept, acc);
        chk("tx_start", tx_start, m_start);
        chk("tx_flit", tx_flit, m_flit);
        chk("link_up", link_up, m_state == 2);
        chk("link_state", link_state, m_state);
        for (int v = 0; v < NV; v++) chk($sformatf("credits%0d", v), credits[v], m_cred[v]);
        chk("err_cnt", err_cnt, m_err);
        chk("credit_ovf", credit_ovf, m_ovf);
        model_step(acc);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_burst(input int n, input bit err);
        rx_done = 1'b1;
        rx_err  = err;
        repeat (n) tick();
        rx_done = 1'b0;
        rx_err  = 1'b0;
    endtask

    task automatic send(input int vc, input logic [FW-1:0] flit);
        sw_if.sw_valid = 1'b1;
        sw_if.sw_vc    = vc[0];
        sw_if.sw_flit  = flit;
        tick();
        sw_if.sw_valid = 1'b0;
        tx_done        = 1'b1;
        tick();
        tx_done        = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; link_en = 1'b0; tx_done = 1'b0; rx_done = 1'b0; rx_err = 1'b0;
        cred_ret = '0;
        sw_if.sw_valid = 1'b0; sw_if.sw_flit = '0; sw_if.sw_vc = '0;
        repeat (3) tick();
        #1;
        chk("lit_rst_state", link_state, 0);
        chk("lit_rst_cred0", credits[0], 0);

        sw_if.sw_valid = 1'b1;
        n_rst = 1'b1;
        tick();
        #1;
        chk("lit_post_rst_up", link_up, 0);
        chk("lit_post_rst_acc", sw_if.sw_accept, 0);
        sw_if.sw_valid = 1'b0;

        // bring-up
        link_en = 1'b1;
        tick();
        rx_burst(16, 0);
        tick();
        #1;
        chk("lit_bringup_up", link_up, 1);
        chk("lit_bringup_cred0", credits[0], 8);
        chk("lit_bringup_cred1", credits[1], 8);

        // credit exhaustion on VC0
        for (int i = 0; i < 8; i++) send(0, 32'hA000_0000 + i);
        #1;
        chk("lit_vc0_empty", credits[0], 0);
        sw_if.sw_valid = 1'b1; sw_if.sw_vc = 1'b0; sw_if.sw_flit = 32'hDEAD_0009;
        #1;
        chk("lit_ninth_blocked", sw_if.sw_accept, 0);
        cred_ret = 2'b01;
        tick();
        cred_ret = 2'b00;
        #1;
        chk("lit_ninth_accept", sw_if.sw_accept, 1);
        chk("lit_vc0_one", credits[0], 1);
        tick();
        sw_if.sw_valid = 1'b0;
        #1;
        chk("lit_ninth_start", tx_start, 1);
        chk("lit_ninth_flit", tx_flit, 32'hDEAD_0009);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;

        // credit race on VC1, then overflow
        send(1, 32'h1111_0001);
        sw_if.sw_valid = 1'b1; sw_if.sw_vc = 1'b1; sw_if.sw_flit = 32'h1111_0002;
        cred_ret = 2'b10;
        tick();
        sw_if.sw_valid = 1'b0;
        cred_ret = 2'b00;
        #1;
        chk("lit_race_cred1", credits[1], 7);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        cred_ret = 2'b10;
        tick();
        #1;
        chk("lit_ret_cred1", credits[1], 8);
        tick();
        cred_ret = 2'b00;
        #1;
        chk("lit_sat_cred1", credits[1], 8);
        chk("lit_ovf", credit_ovf, 1);

        // fault
        rx_burst(4, 1);
        #1;
        chk("lit_err4", err_cnt, 4);
        tick();
        #1;
        chk("lit_fault", link_state, 3);
        sw_if.sw_valid = 1'b1; sw_if.sw_vc = 1'b1;
        #1;
        chk("lit_fault_no_acc", sw_if.sw_accept, 0);
        sw_if.sw_valid = 1'b0;
        link_en = 1'b0;
        tick();
        #1;
        chk("lit_fault_down", link_state, 0);
        link_en = 1'b1;
        tick();
        #1;
        chk("lit_retrain", link_state, 1);

        // training with an error in the middle
        rx_burst(10, 0);
        rx_burst(1, 1);
        rx_burst(15, 0);
        tick();
        #1;
        chk("lit_train15", link_state, 1);
        rx_burst(1, 0);
        tick();
        #1;
        chk("lit_train_up", link_state, 2);
        chk("lit_train_err0", err_cnt, 0);

        // reset in the middle of a transmission
        sw_if.sw_valid = 1'b1; sw_if.sw_vc = 1'b1; sw_if.sw_flit = 32'hC0DE_0001;
        tick();
        sw_if.sw_valid = 1'b0;
        #1;
        chk("lit_mid_start", tx_start, 1);
        n_rst = 1'b0;
        tick();
        #1;
        chk("lit_mid_rst_start", tx_start, 0);
        chk("lit_mid_rst_flit", tx_flit, 0);
        chk("lit_mid_rst_state", link_state, 0);
        chk("lit_mid_rst_cred1", credits[1], 0);
        chk("lit_mid_rst_ovf", credit_ovf, 0);
        tick();
        n_rst = 1'b1;
        repeat (4) tick();
        #1;
        chk("lit_post_mid_start", tx_start, 0);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tile_link_ctrl.md
TILE_LINK_CTRL -- requirements
Module: tile_link_ctrl

Interface
REQ-001 SHALL have parameter NUM_VCS, default 2: number of virtual channels with independent credit tracking.
REQ-002 SHALL have parameter FLIT_WIDTH, default 32: flit width in bits.
REQ-003 SHALL have parameter CREDIT_DEPTH, default 8: far-end buffer depth per VC, which is also the initial credit count.
REQ-004 SHALL have parameter TRAIN_FLITS, default 16: consecutive clean received flits required for link-up.
REQ-005 SHALL have parameter ERR_THRESH, default 4: number of receive errors while up that forces FAULT.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port n_rst, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port link_en, input, 1 bit: software enable for link bring-up.
REQ-009 SHALL have port sw_valid, input, 1 bit: the switch output port offers a flit.
REQ-010 SHALL have port sw_flit, input, FLIT_WIDTH bits: the offered flit.
REQ-011 SHALL have port sw_vc, input, $clog2(NUM_VCS) bits: VC of the offered flit.
REQ-012 SHALL have port sw_accept, output, 1 bit: flit accepted this cycle (drives the switch packet_sent).
REQ-013 SHALL have port tx_flit, output, FLIT_WIDTH bits: flit toward the endnode/PHY transmitter.
REQ-014 SHALL have port tx_start, output, 1 bit: one-cycle transmit start pulse.
REQ-015 SHALL have port tx_done, input, 1 bit: the transmitter finished the current flit.
REQ-016 SHALL have port cred_ret, input, NUM_VCS bits: per-VC credit return pulses from the far end.
REQ-017 SHALL have port rx_done, input, 1 bit: a flit was received.
REQ-018 SHALL have port rx_err, input, 1 bit: the received flit had an error; qualified by rx_done.
REQ-019 SHALL have port link_up, output, 1 bit: the FSM is in UP.
REQ-020 SHALL have port link_state, output, 2 bits: the encoded FSM state.
REQ-021 SHALL have port credits, output, NUM_VCS x $clog2(CREDIT_DEPTH+1) bits: current credit count per VC.
REQ-022 SHALL have port err_cnt, output, $clog2(ERR_THRESH+1) bits: receive errors counted while UP.
REQ-023 SHALL have port credit_ovf, output, 1 bit: sticky flag, set when a credit return arrives at full credit.

Function
REQ-024 SHALL implement the FSM states DOWN=0, TRAIN=1, UP=2, FAULT=3, with link_state equal to the state encoding.
REQ-025 SHALL move DOWN->TRAIN when link_en=1, and SHALL clear the train counter on that transition.
REQ-026 In TRAIN, each rx_done with rx_err=0 SHALL increment the train counter; rx_done with rx_err=1 SHALL clear it.
REQ-027 In TRAIN, a counter value of TRAIN_FLITS SHALL cause TRAIN->UP on the next edge; entering UP SHALL load every credit counter to CREDIT_DEPTH and clear err_cnt.
REQ-028 In UP, each rx_done with rx_err=1 SHALL increment err_cnt; err_cnt reaching ERR_THRESH SHALL cause UP->FAULT on the next edge.
REQ-029 FAULT SHALL hold until link_en=0, then move to DOWN; link_en=0 in TRAIN or UP SHALL move the FSM directly to DOWN.
REQ-030 The transmit path SHALL have two states, IDLE and BUSY.
REQ-031 In IDLE, sw_accept SHALL be combinational: sw_accept = state UP & sw_valid & credits[sw_vc] != 0.
REQ-032 On an accept, the block SHALL register sw_flit into tx_flit, pulse tx_start on the next cycle, and enter BUSY.
REQ-033 In BUSY, sw_accept SHALL be 0; tx_done SHALL return the path to IDLE, and a new flit may be accepted on the following cycle.
REQ-034 Each accept SHALL decrement credits[sw_vc] by 1.
REQ-035 Each cred_ret[v] pulse SHALL increment credits[v] by 1.
REQ-036 A simultaneous decrement and increment on the same VC SHALL leave the count unchanged.
REQ-037 An increment at CREDIT_DEPTH SHALL saturate the count and set credit_ovf.
REQ-038 cred_ret SHALL be ignored outside UP.
REQ-039 A flit in BUSY when the FSM leaves UP SHALL be abandoned: the transmit path SHALL return to IDLE immediately, with no further tx_start.
REQ-040 An out-of-range sw_vc (>= NUM_VCS) SHALL never be accepted.

Reset
REQ-041 While n_rst=0 at a clock edge: state=DOWN, transmit path IDLE, tx_start=0, tx_flit=0, credits=0, err_cnt=0, train counter=0, credit_ovf=0.
REQ-042 link_up and sw_accept SHALL be 0 while reset is asserted and in the cycle after it is released.
REQ-043 Reset asserted mid-transmission SHALL discard the in-flight flit; no tx_start SHALL follow reset release.

Structure
REQ-044 A shared package tile_link_pkg SHALL hold the link_state_t enum (DOWN/TRAIN/UP/FAULT), the tx_state_t enum, and the default parameter constants.
REQ-045 One sub-module, link_credit_ctr, SHALL implement a single saturating up/down counter with load and overflow flag, instantiated NUM_VCS times via generate.
REQ-046 The target size SHALL be approximately 200-300 lines of RTL in total.

Verification
REQ-047 Bring-up: link_en=1 with 16 clean rx_done -> link_up=1 two cycles later; credits={8,8}.
REQ-048 Training error: 10 clean rx_done, then 1 rx_err, then 15 clean -> still TRAIN; one more clean -> UP.
REQ-049 Credit exhaustion: 8 flits on VC0 with tx_done after each -> credits[0]=0 and the 9th is not accepted. Then cred_ret[0] pulse -> the 9th is accepted the next cycle.
REQ-050 Credit race: accept on VC1 and cred_ret[1] in the same cycle -> credits[1] unchanged. A cred_ret at 8 -> count stays 8 and credit_ovf=1.
REQ-051 Fault: 4 rx_err in UP -> FAULT, sw_accept=0. Then link_en=0 -> DOWN, and link_en=1 -> TRAIN.
REQ-052 Mid-flight reset: n_rst=0 during BUSY -> all outputs at reset values; no tx_start after release.
